// File: rtl/prog_mem_pkg.sv
// Shared program-memory widths, loader state encoding and length limits.
// Imported by the boot loader and its byte packer.
package prog_mem_pkg;

    localparam int I_MEM_ADDR_W   = 11;
    localparam int I_MEM_DATA_W   = 32;
    localparam int I_MEM_DEPTH    = 2048;
    localparam int BYTES_PER_WORD = 4;
    localparam int LOADER_LEN_W   = I_MEM_ADDR_W + 1;

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        WRITE,
        DONE
    } loader_state_t;

endpackage

// File: rtl/byte_packer.sv
// Packs a byte stream into 32-bit words with a 2-bit byte counter.
// word is the assembled value including the byte presented this cycle.
module byte_packer
    import prog_mem_pkg::*;
#(
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    input  logic        clear,
    output logic [31:0] word,
    output logic        word_valid
);

    logic [31:0] acc_q, acc_d;
    logic [1:0]  cnt_q, cnt_d;

    always_comb begin
        if (MSB_FIRST) begin
            word = {acc_q[23:0], in_data};
        end else begin
            word = {in_data, acc_q[31:8]};
        end
        word_valid = in_valid && !clear &&
                     (cnt_q == 2'(BYTES_PER_WORD - 1));
        acc_d = acc_q;
        cnt_d = cnt_q;
        if (clear) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (in_valid) begin
            acc_d = word;
            cnt_d = cnt_q + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/prog_mem_loader.sv
// Boot-time loader: packs a byte stream into words, writes them to
// program memory at ascending addresses and holds the core in reset.
module prog_mem_loader
    import prog_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = I_MEM_ADDR_W,
    parameter int DATA_WIDTH = I_MEM_DATA_W,
    parameter int MEM_DEPTH  = I_MEM_DEPTH,
    parameter bit MSB_FIRST  = 1'b1,
    parameter bit HOLD_CORE  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   len_words,
    input  logic                  abort,
    input  logic                  s_valid,
    input  logic [7:0]            s_data,
    output logic                  s_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_waddr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  core_rst_n,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int LEN_W = ADDR_WIDTH + 1;

    loader_state_t         state_q, state_d;
    logic [LEN_W-1:0]      len_q, len_d;
    logic [ADDR_WIDTH-1:0] word_cnt_q, word_cnt_d;
    logic                  s_ready_q, s_ready_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_waddr_q, mem_waddr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic                  core_rst_n_q, core_rst_n_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;

    logic        take;
    logic        len_ok;
    logic        last_word;
    logic        pk_clear;
    logic [31:0] pk_word;
    logic        pk_word_valid;

    assign take      = s_valid && s_ready_q && (state_q == RECV);
    assign len_ok    = (len_words != '0) &&
                       (len_words <= LEN_W'(MEM_DEPTH));
    assign last_word = ({1'b0, word_cnt_q} == (len_q - LEN_W'(1)));
    // Packer is held empty outside a load so a new image starts aligned.
    assign pk_clear  = (state_q == IDLE) || abort;

    byte_packer #(
        .MSB_FIRST (MSB_FIRST)
    ) u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (take),
        .in_data    (s_data),
        .clear      (pk_clear),
        .word       (pk_word),
        .word_valid (pk_word_valid)
    );

    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        word_cnt_d   = word_cnt_q;
        s_ready_d    = s_ready_q;
        mem_we_d     = 1'b0;
        mem_waddr_d  = mem_waddr_q;
        mem_wdata_d  = mem_wdata_q;
        core_rst_n_d = core_rst_n_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        err_d        = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start && len_ok) begin
                    len_d        = len_words;
                    word_cnt_d   = '0;
                    core_rst_n_d = 1'b0;
                    busy_d       = 1'b1;
                    s_ready_d    = 1'b1;
                    state_d      = RECV;
                end else if (start) begin
                    err_d = 1'b1;
                end
            end
            RECV: begin
                if (abort) begin
                    err_d     = 1'b1;
                    busy_d    = 1'b0;
                    s_ready_d = 1'b0;
                    state_d   = IDLE;
                end else if (pk_word_valid) begin
                    mem_wdata_d = DATA_WIDTH'(pk_word);
                    mem_waddr_d = word_cnt_q;
                    s_ready_d   = 1'b0;
                    state_d     = WRITE;
                end
            end
            WRITE: begin
                // The strobe is committed at the end of WRITE so abort can veto it.
                if (abort) begin
                    err_d     = 1'b1;
                    busy_d    = 1'b0;
                    s_ready_d = 1'b0;
                    state_d   = IDLE;
                end else begin
                    mem_we_d = 1'b1;
                    if (last_word) begin
                        state_d = DONE;
                    end else begin
                        word_cnt_d = word_cnt_q + 1'b1;
                        s_ready_d  = 1'b1;
                        state_d    = RECV;
                    end
                end
            end
            DONE: begin
                done_d       = 1'b1;
                core_rst_n_d = 1'b1;
                busy_d       = 1'b0;
                state_d      = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            len_q        <= '0;
            word_cnt_q   <= '0;
            s_ready_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_waddr_q  <= '0;
            mem_wdata_q  <= '0;
            core_rst_n_q <= ~HOLD_CORE;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            word_cnt_q   <= word_cnt_d;
            s_ready_q    <= s_ready_d;
            mem_we_q     <= mem_we_d;
            mem_waddr_q  <= mem_waddr_d;
            mem_wdata_q  <= mem_wdata_d;
            core_rst_n_q <= core_rst_n_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign s_ready    = s_ready_q;
    assign mem_we     = mem_we_q;
    assign mem_waddr  = mem_waddr_q;
    assign mem_wdata  = mem_wdata_q;
    assign core_rst_n = core_rst_n_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_prog_mem_loader.sv
// Scoreboard bench for prog_mem_loader: MSB-first and LSB-first instances
// share the byte stream; each has its own start and expected-write queue.
module tb_prog_mem_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start_m = 1'b0;
    logic        start_l = 1'b0;
    logic [11:0] len_words = '0;
    logic        abort = 1'b0;
    logic        s_valid = 1'b0;
    logic [7:0]  s_data = '0;

    logic        s_ready_m, we_m, crn_m, busy_m, done_m, err_m;
    logic [10:0] waddr_m;
    logic [31:0] wdata_m;
    logic        s_ready_l, we_l, crn_l, busy_l, done_l, err_l;
    logic [10:0] waddr_l;
    logic [31:0] wdata_l;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [42:0] q_m[$];
    logic [42:0] q_l[$];
    int we_cnt_m = 0, we_cnt_l = 0;
    int done_cnt_m = 0, done_cnt_l = 0;
    int err_cnt_m = 0, err_cnt_l = 0;
    int last_we_cyc_m = -10, last_we_cyc_l = -10;
    logic [10:0] last_addr_m = '0;
    logic err_prev_m = 1'b0, err_prev_l = 1'b0;
    int wc_l[$];

    prog_mem_loader #(.MSB_FIRST(1'b1), .HOLD_CORE(1'b1)) dut_m (
        .clk(clk), .rst_n(rst_n), .start(start_m), .len_words(len_words),
        .abort(abort), .s_valid(s_valid), .s_data(s_data),
        .s_ready(s_ready_m), .mem_we(we_m), .mem_waddr(waddr_m),
        .mem_wdata(wdata_m), .core_rst_n(crn_m), .busy(busy_m),
        .done(done_m), .err(err_m)
    );

    prog_mem_loader #(.MSB_FIRST(1'b0), .HOLD_CORE(1'b1)) dut_l (
        .clk(clk), .rst_n(rst_n), .start(start_l), .len_words(len_words),
        .abort(abort), .s_valid(s_valid), .s_data(s_data),
        .s_ready(s_ready_l), .mem_we(we_l), .mem_waddr(waddr_l),
        .mem_wdata(wdata_l), .core_rst_n(crn_l), .busy(busy_l),
        .done(done_l), .err(err_l)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (we_m) begin
                we_cnt_m++;
                last_we_cyc_m = cyc;
                last_addr_m = waddr_m;
                if (q_m.size() == 0) chk("unexpected_write_m", {waddr_m, wdata_m}, 0);
                else chk("write_m", {waddr_m, wdata_m}, q_m.pop_front());
            end
            if (done_m) begin
                done_cnt_m++;
                chk("done_timing_m", cyc, last_we_cyc_m + 1);
                chk("done_core_rst_m", crn_m, 1);
            end
            if (err_m) begin
                err_cnt_m++;
                chk("err_width_m", err_prev_m, 0);
            end
            err_prev_m = err_m;
            if (we_l) begin
                we_cnt_l++;
                last_we_cyc_l = cyc;
                wc_l.push_back(cyc);
                if (q_l.size() == 0) chk("unexpected_write_l", {waddr_l, wdata_l}, 0);
                else chk("write_l", {waddr_l, wdata_l}, q_l.pop_front());
            end
            if (done_l) begin
                done_cnt_l++;
                chk("done_timing_l", cyc, last_we_cyc_l + 1);
            end
            if (err_l) err_cnt_l++;
            err_prev_l = err_l;
        end
    end

    function automatic logic rdy(input bit sel);
        return sel ? s_ready_l : s_ready_m;
    endfunction

    task automatic do_start(input bit sel, input int len);
        @(posedge clk); #1;
        len_words = 12'(len);
        if (sel) start_l = 1'b1; else start_m = 1'b1;
        @(posedge clk); #1;
        start_m = 1'b0;
        start_l = 1'b0;
    endtask

    task automatic send_byte(input bit sel, input logic [7:0] b,
                             input int gap, input bit ab);
        int n;
        s_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk); #1;
        end
        s_valid = 1'b1;
        s_data = b;
        abort = ab;
        n = 0;
        forever begin
            @(negedge clk);
            if (rdy(sel)) break;
            n++;
            if (n > 100) begin
                chk("s_ready_timeout", 0, 1);
                break;
            end
        end
        @(posedge clk); #1;
        s_valid = 1'b0;
        abort = 1'b0;
    endtask

    task automatic send_word(input bit sel, input logic [31:0] w);
        for (int i = 0; i < 4; i++) begin
            logic [31:0] t;
            t = w << (8 * i);
            send_byte(sel, t[31:24], 0, 1'b0);
        end
    endtask

    task automatic wait_done(input bit sel, input int target, input int budget);
        int n;
        n = 0;
        while ((sel ? done_cnt_l : done_cnt_m) < target) begin
            @(negedge clk);
            n++;
            if (n > budget) begin
                chk("done_timeout", n, 0);
                break;
            end
        end
    endtask

    task automatic check_reset_outputs(input string nm);
        chk({nm, "_ctl_m"}, {s_ready_m, we_m, busy_m, done_m, err_m, crn_m}, 0);
        chk({nm, "_addr_data_m"}, {waddr_m, wdata_m}, 0);
        chk({nm, "_ctl_l"}, {s_ready_l, we_l, busy_l, done_l, err_l, crn_l}, 0);
    endtask

    int we0, err0, n0;

    initial begin
        // Reset asserted mid-cycle; outputs must clear without a clock edge
        #3 rst_n = 1'b0;
        #1 check_reset_outputs("reset");
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

        // Normal MSB-first load
        q_m.push_back({11'd0, 32'h11223344});
        q_m.push_back({11'd1, 32'h55667788});
        do_start(0, 2);
        send_word(0, 32'h11223344);
        send_word(0, 32'h55667788);
        wait_done(0, 1, 50);
        chk("normal_writes", we_cnt_m, 2);
        chk("normal_core_rst", crn_m, 1);
        chk("normal_busy", busy_m, 0);

        // LSB-first, then the same with a 3-cycle gap inside word 1
        q_l.push_back({11'd0, 32'h44332211});
        q_l.push_back({11'd1, 32'h88776655});
        do_start(1, 2);
        send_word(1, 32'h11223344);
        send_word(1, 32'h55667788);
        wait_done(1, 1, 50);
        chk("lsb_spacing", wc_l[1] - wc_l[0], 5);
        q_l.push_back({11'd0, 32'h44332211});
        q_l.push_back({11'd1, 32'h88776655});
        do_start(1, 2);
        send_word(1, 32'h11223344);
        send_byte(1, 8'h55, 0, 1'b0);
        send_byte(1, 8'h66, 3, 1'b0);
        send_byte(1, 8'h77, 0, 1'b0);
        send_byte(1, 8'h88, 0, 1'b0);
        wait_done(1, 2, 50);
        chk("gap_spacing", wc_l[3] - wc_l[2], 8);
        chk("lsb_writes", we_cnt_l, 4);

        // Bad lengths
        we0 = we_cnt_m;
        err0 = err_cnt_m;
        do_start(0, 0);
        repeat (3) @(negedge clk);
        chk("len0_err", err_cnt_m - err0, 1);
        chk("len0_busy_core", {busy_m, crn_m}, 2'b01);
        do_start(0, 2049);
        repeat (3) @(negedge clk);
        chk("len2049_err", err_cnt_m - err0, 2);
        chk("len2049_busy_core", {busy_m, crn_m}, 2'b01);
        chk("badlen_no_write", we_cnt_m - we0, 0);

        // Full-depth load
        for (int i = 0; i < 2048; i++)
            q_m.push_back({11'(i), 32'hC0DE0000 | 32'(i)});
        do_start(0, 2048);
        chk("full_core_held", crn_m, 0);
        for (int i = 0; i < 2048; i++) send_word(0, 32'hC0DE0000 | 32'(i));
        wait_done(0, 2, 50);
        chk("full_writes", we_cnt_m - we0, 2048);
        chk("full_last_addr", last_addr_m, 11'd2047);

        // Abort with the 4th byte of word 1; a mid-load start is ignored
        we0 = we_cnt_m;
        err0 = err_cnt_m;
        q_m.push_back({11'd0, 32'hAABBCCDD});
        do_start(0, 3);
        send_word(0, 32'hAABBCCDD);
        len_words = 12'd1;
        start_m = 1'b1;
        send_byte(0, 8'h01, 0, 1'b0);
        start_m = 1'b0;
        send_byte(0, 8'h02, 0, 1'b0);
        send_byte(0, 8'h03, 0, 1'b0);
        send_byte(0, 8'h04, 0, 1'b1);
        repeat (6) @(negedge clk);
        chk("abort_writes", we_cnt_m - we0, 1);
        chk("abort_err", err_cnt_m - err0, 1);
        chk("abort_state", {s_ready_m, busy_m, crn_m}, 3'b000);

        // Async reset after word 0, then a fresh single-word load
        q_m.push_back({11'd0, 32'h01020304});
        we0 = we_cnt_m;
        do_start(0, 4);
        send_word(0, 32'h01020304);
        n0 = 0;
        while (we_cnt_m == we0 && n0 < 20) begin
            @(negedge clk);
            n0++;
        end
        chk("pre_reset_write", we_cnt_m - we0, 1);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 check_reset_outputs("midload_reset");
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        we0 = we_cnt_m;
        q_m.push_back({11'd0, 32'hDEADBEEF});
        do_start(0, 1);
        send_word(0, 32'hDEADBEEF);
        wait_done(0, 3, 50);
        chk("reload_writes", we_cnt_m - we0, 1);
        chk("reload_core_rst", crn_m, 1);

        repeat (3) @(negedge clk);
        chk("queue_m_empty", q_m.size(), 0);
        chk("queue_l_empty", q_l.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
